// File: rtl/hamming_serial_rx.sv
// hamming_serial_rx: frames a bit-serial Hamming codeword stream, corrects single-bit errors and delivers data over valid/ready.
module hamming_serial_rx #(
  parameter int P = 3,
  localparam int N = 2**P - 1,
  localparam int K = 2**P - P - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_bit,
  input  logic         rx_valid,
  input  logic         rx_sof,
  output logic [K-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_corrected,
  output logic [P-1:0] out_syndrome,
  output logic [7:0]   err_count,
  output logic         overrun
);
  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;
  localparam logic [P-1:0] LAST = P'(N - 1);
  state_t state, state_nx;
  logic [N-1:0] cw, fixed;
  logic [P-1:0] cnt, syn;
  logic [K-1:0] dec_data;
  logic sof, hs;
  function automatic int dpos(int j);
    int c, r;
    c = 0;
    r = 1;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        if (c == j) r = p;
        c++;
      end
    return r;
  endfunction
  assign sof = rx_valid && rx_sof;
  assign hs = out_valid && out_ready;
  always_comb begin
    syn = '0;
    for (int i = 0; i < N; i++) syn = syn ^ (cw[i] ? P'(i + 1) : '0);
  end
  assign fixed = cw ^ ((syn != '0) ? (N'(1) << (syn - 1'b1)) : '0);
  for (genvar d = 0; d < K; d++) begin : g_data
    assign dec_data[d] = fixed[dpos(d) - 1];
  end
  // An rx_sof always (re)starts a frame, including in the DECODE cycle
  always_comb begin
    state_nx = sof ? SHIFT
             : (state == SHIFT && rx_valid && cnt == LAST) ? DECODE
             : (state == DECODE) ? IDLE
             : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw <= '0;
      cnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_corrected <= 1'b0;
      out_syndrome <= '0;
      err_count <= '0;
      overrun <= 1'b0;
    end else begin
      if (sof) begin
        cw <= {{(N-1){1'b0}}, rx_bit};
        cnt <= P'(1);
      end else if (state == SHIFT && rx_valid) begin
        cw[cnt] <= rx_bit;
        cnt <= cnt + 1'b1;
      end else if (state == DECODE) begin
        cnt <= '0;
      end
      if (state == DECODE) begin
        if (out_valid && !out_ready) overrun <= 1'b1;
        else begin
          out_data <= dec_data;
          out_corrected <= syn != '0;
          out_syndrome <= syn;
          out_valid <= 1'b1;
        end
        if (syn != '0 && err_count != 8'hff) err_count <= err_count + 8'd1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hamming_serial_rx.sv
// tb_hamming_serial_rx: directed table-driven bench for the P=3 serial Hamming receiver.
module tb_hamming_serial_rx;
  logic clk = 1'b0, rst = 1'b1;
  logic rx_bit = 1'b0, rx_valid = 1'b0, rx_sof = 1'b0, out_ready = 1'b1;
  logic [3:0] out_data;
  logic out_valid, out_corrected, overrun;
  logic [2:0] out_syndrome;
  logic [7:0] err_count;
  int checks = 0, passes = 0, errs = 0;
  typedef struct {
    logic [6:0] cw;
    logic [3:0] data;
    logic corr;
    logic [2:0] syn;
  } vec_t;
  vec_t vecs[12];
  hamming_serial_rx #(.P(3)) dut (
    .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_valid(rx_valid), .rx_sof(rx_sof),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_corrected(out_corrected), .out_syndrome(out_syndrome),
    .err_count(err_count), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic drive(input logic b, input logic v, input logic s);
    rx_bit = b;
    rx_valid = v;
    rx_sof = s;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [6:0] cw);
    for (int i = 0; i < 7; i++) drive(cw[i], 1'b1, i == 0);
  endtask
  initial begin
    vecs[0]  = '{7'b1010101, 4'b1011, 1'b0, 3'd0};
    vecs[1]  = '{7'b1110101, 4'b1011, 1'b1, 3'd6};
    vecs[2]  = '{7'b0000001, 4'b0000, 1'b1, 3'd1};
    vecs[3]  = '{7'b0000010, 4'b0000, 1'b1, 3'd2};
    vecs[4]  = '{7'b0000100, 4'b0000, 1'b1, 3'd3};
    vecs[5]  = '{7'b0001000, 4'b0000, 1'b1, 3'd4};
    vecs[6]  = '{7'b0010000, 4'b0000, 1'b1, 3'd5};
    vecs[7]  = '{7'b0100000, 4'b0000, 1'b1, 3'd6};
    vecs[8]  = '{7'b1000000, 4'b0000, 1'b1, 3'd7};
    vecs[9]  = '{7'b0000000, 4'b0000, 1'b0, 3'd0};
    vecs[10] = '{7'b1111111, 4'b1111, 1'b0, 3'd0};
    vecs[11] = '{7'b1000111, 4'b0001, 1'b1, 3'd7};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_corr", out_corrected, 0);
    chk("rst_syn", out_syndrome, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_overrun", overrun, 0);
    foreach (vecs[v]) begin
      send(vecs[v].cw);
      chk($sformatf("v%0d_decode_cycle_valid", v), out_valid, 0);
      drive(1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_valid", v), out_valid, 1);
      chk($sformatf("v%0d_data", v), out_data, vecs[v].data);
      chk($sformatf("v%0d_corr", v), out_corrected, vecs[v].corr);
      chk($sformatf("v%0d_syn", v), out_syndrome, vecs[v].syn);
      drive(1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_valid_drop", v), out_valid, 0);
      if (vecs[v].syn != 0) errs++;
    end
    chk("table_errcnt", err_count, errs);
    out_ready = 1'b0;
    send(7'b1010101);
    drive(1'b0, 1'b0, 1'b0);
    chk("ovr_first_valid", out_valid, 1);
    chk("ovr_first_data", out_data, 4'b1011);
    chk("ovr_flag_before", overrun, 0);
    send(7'b0000111);
    drive(1'b0, 1'b0, 1'b0);
    chk("ovr_flag", overrun, 1);
    chk("ovr_held_data", out_data, 4'b1011);
    chk("ovr_held_valid", out_valid, 1);
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    chk("ovr_delivered", out_valid, 0);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_errcnt", err_count, errs);
    drive(1'b1, 1'b1, 1'b1);
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) repeat (2) drive(1'b0, 1'b0, 1'b0);
      drive(vecs[0].cw[i], 1'b1, i == 0);
    end
    chk("restart_decode_cycle_valid", out_valid, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("restart_valid", out_valid, 1);
    chk("restart_data", out_data, 4'b1011);
    chk("restart_corr", out_corrected, 0);
    drive(1'b0, 1'b0, 1'b0);
    // back-to-back frames: each rx_sof lands in the previous frame's DECODE cycle
    for (int f = 0; f < 300; f++) send(7'b0000001);
    drive(1'b0, 1'b0, 1'b0);
    chk("sat_last_valid", out_valid, 1);
    chk("sat_last_syn", out_syndrome, 3'd1);
    chk("sat_last_data", out_data, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("sat_errcnt", err_count, 8'd255);
    out_ready = 1'b0;
    send(7'b1110101);
    drive(1'b0, 1'b0, 1'b0);
    chk("prerst_valid", out_valid, 1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_data", out_data, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_corr", out_corrected, 0);
    chk("arst_syn", out_syndrome, 0);
    chk("arst_errcnt", err_count, 0);
    chk("arst_overrun", overrun, 0);
    #1;
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_sof = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(7'b1010101);
    chk("postrst_decode_cycle_valid", out_valid, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("postrst_valid", out_valid, 1);
    chk("postrst_data", out_data, 4'b1011);
    chk("postrst_errcnt", err_count, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("postrst_valid_drop", out_valid, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/hamming_serial_rx.md
# hamming_serial_rx

Serial receive-side Hamming block: it accepts a bit-serial stream of Hamming codewords, frames and deserialises each codeword, and computes the syndrome. It corrects any single-bit error and delivers the recovered data word over a valid/ready handshake. It sits at the far end of the link from the Hamming encoder, after the channel where bit errors are injected. It also keeps link statistics: a saturating error count and a sticky overrun flag.

## Interface
- P, default 3: parity bit count. Codeword length N = 2**P-1; data width K = 2**P-P-1.
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_bit  input  1  serial codeword bit.
- rx_valid  input  1  qualifies rx_bit; exactly one bit is accepted per cycle with rx_valid=1.
- rx_sof  input  1  start of frame; meaningful only when rx_valid=1; marks rx_bit as codeword position 1.
- out_data  output  K  corrected data word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- out_corrected  output  1  a nonzero syndrome was found and one bit was flipped for this word.
- out_syndrome  output  P  raw syndrome of this word.
- err_count  output  8  count of codewords with a nonzero syndrome; saturates at 255.
- overrun  output  1  sticky; a decoded word was dropped because the output was still occupied.

## Operation
- Codeword convention: vector bit i holds position i+1.
  - Parity bits sit at power-of-two positions (1,2,4,...).
  - Data bit j sits at the j-th non-power-of-two position, in ascending order; for P=3, data[0..3] are at positions 3,5,6,7.
- Serial order: position 1 first (vector LSB first).
- States:
  - IDLE: rx_valid && !rx_sof bits are discarded. rx_valid && rx_sof loads position 1, sets bit counter to 1 and moves to SHIFT.
  - SHIFT: each rx_valid bit is stored at position counter+1. rx_valid && rx_sof restarts the frame: the partial frame is discarded and the bit becomes position 1. Acceptance of position N moves to DECODE.
  - DECODE (one cycle):
    - Syndrome = XOR of the position indices of all set bits.
    - If the syndrome is nonzero, invert the bit at position = syndrome.
    - Extract the data bits and load the output register.
    - Next state is SHIFT if rx_valid && rx_sof this cycle (that bit becomes position 1), else IDLE. Other rx_valid bits in this cycle are discarded.
- Output register (one entry):
  - If DECODE occurs while out_valid=1 and no handshake occurs that cycle, the new word is dropped, overrun sets and stays set until rst, and err_count still updates.
  - If the handshake and DECODE coincide, the new word replaces the old one with no overrun.
- err_count increments in DECODE when the syndrome is nonzero; it holds at 255.
- Plain Hamming code: a double error is miscorrected silently; no detection is required.

## Timing
- Reset values: out_data=0, out_valid=0, out_corrected=0, out_syndrome=0, err_count=0, overrun=0. State=IDLE, bit counter=0.
- rst asserted mid-frame or mid-hold aborts everything immediately; the partial frame is lost.
- Latency: position N is accepted at edge k, DECODE is the cycle after edge k, and out_valid=1 after edge k+1.
- Back-to-back frames need one idle cycle between the last bit and the next rx_sof, or an rx_sof landing in the DECODE cycle.
- out_valid stays high with out_data, out_corrected and out_syndrome stable until the handshake edge.
- out_valid falls after the handshake edge unless DECODE loads a new word on the same edge.
- Gaps in rx_valid mid-frame are allowed; the counter holds.

## Test plan
- P=3, data 4'b1011 is sent as codeword 7'b1010101 (LSB first, rx_sof on the first bit), out_ready=1 -> out_data=4'b1011, out_corrected=0, out_syndrome=0, out_valid high exactly 1 cycle, 2 edges after the last bit.
- Codeword 7'b1110101 (position 6 flipped) -> out_data=4'b1011, out_corrected=1, out_syndrome=3'd6, err_count=1.
- Each single-bit error at positions 1..7 on the all-zero codeword -> out_data=0, out_syndrome equals the position; after all 7, err_count=7.
- out_ready=0 while a second codeword completes -> first word held unchanged, overrun=1, second word dropped. Raise out_ready -> first word delivered; overrun stays 1 until rst.
- rx_sof issued after 4 bits of a frame, then a full valid codeword -> only the new codeword is decoded. Also, 300 errored codewords -> err_count=255.
- rst pulse asynchronously mid-frame and while out_valid=1 -> all outputs return to zero immediately, and the next complete frame decodes correctly.
